nes_pad_reader: RTL and testbench

//  Serial front end for the NES controller, directly upstream of nestovga.

---
 rtl/nes_pkg.sv | 26 ++
 rtl/nes_pad_reader_sync2.sv | 21 ++
 rtl/nes_pad_reader.sv | 175 +++++++++++++++++
 tb/tb_nes_pad_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared NES controller definitions, also used by the nestovga video stage.
//   nes_state_t : reader FSM states
//   BTN_*       : bit positions of each button in the 8-bit button vector
//   NES_BITS    : number of serial bits shifted out per poll
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } nes_state_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NES_BITS   = 8;

endpackage

// File: rtl/nes_pad_reader_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
//   clk_i : destination clock
//   d_i   : asynchronous input
//   q_o   : synchronized output, two clocks of latency
module sync2 (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        meta_q <= d_i;
        sync_q <= meta_q;
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller serial reader. Periodically pulses the latch line, clocks
// out 8 active-low button bits and presents them as an active-high vector
// with a one-cycle valid strobe and newly-pressed flags.
//   clock_50mhz     : system clock, rising edge
//   reset           : synchronous, active-low
//   nes_data        : controller serial data (asynchronous, active-low)
//   clklatch        : controller latch pulse, active-high
//   clkout          : controller shift clock, idles low
//   buttons         : [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   buttons_valid   : one-cycle strobe, buttons updated this cycle
//   buttons_pressed : rising-edge flags, nonzero only with buttons_valid
module nes_pad_reader
    import nes_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int POLL_HZ      = 60,
    parameter int HALF_CYCLES  = 300,
    parameter int LATCH_CYCLES = 600
) (
    input  logic       clock_50mhz,
    input  logic       reset,
    input  logic       nes_data,
    output logic       clklatch,
    output logic       clkout,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic [7:0] buttons_pressed
);

    localparam int POLL_CYCLES = CLK_HZ / POLL_HZ;
    localparam int PHASE_MAX   = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PH_W        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int POLL_W      = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    // A transfer must finish well before the next tick, otherwise every
    // other tick would be dropped and the poll rate silently halves.
    if (POLL_CYCLES <= LATCH_CYCLES + 16 * HALF_CYCLES + 4) begin : g_bad_params
        $error("nes_pad_reader: POLL_CYCLES too small for one transfer");
    end

    logic data_s;

    sync2 u_sync (
        .clk_i (clock_50mhz),
        .d_i   (nes_data),
        .q_o   (data_s)
    );

    // ------------------------------------------------------------------
    // Free-running poll counter
    // ------------------------------------------------------------------
    logic [POLL_W-1:0] poll_q, poll_d;
    logic              poll_tick;

    assign poll_tick = (poll_q == POLL_W'(POLL_CYCLES - 1));
    assign poll_d    = poll_tick ? '0 : poll_q + POLL_W'(1);

    always_ff @(posedge clock_50mhz) begin
        if (!reset) poll_q <= '0;
        else        poll_q <= poll_d;
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    nes_state_t    state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      sr_q, sr_d;

    logic latch_last, half_last;
    assign latch_last = (phase_q == PH_W'(LATCH_CYCLES - 1));
    assign half_last  = (phase_q == PH_W'(HALF_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                idx_d   = '0;
                // Ticks arriving mid-transfer are simply not seen here.
                if (poll_tick) state_d = LATCH;
            end
            LATCH: begin
                if (latch_last) begin
                    // Bit 0 (A) is already on the line while latch is high.
                    sr_d[0] = data_s;
                    idx_d   = 4'd1;
                    phase_d = '0;
                    state_d = HIGH;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            HIGH: begin
                if (half_last) begin
                    phase_d = '0;
                    state_d = (idx_q == 4'd8) ? DONE : LOW;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            LOW: begin
                if (half_last) begin
                    // Sample at the end of the low phase so the bit shifted
                    // by the previous rising edge has settled through sync2.
                    sr_d[idx_q[2:0]] = data_s;
                    idx_d   = idx_q + 4'd1;
                    phase_d = '0;
                    state_d = HIGH;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_50mhz) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
        end
    end

    // ------------------------------------------------------------------
    // Output registers. Pad lines decode the next state so they are
    // glitch-free flops yet still track the state register cycle for cycle.
    // ------------------------------------------------------------------
    logic       clklatch_q, clkout_q, valid_q;
    logic [7:0] buttons_q, pressed_q;

    always_ff @(posedge clock_50mhz) begin
        if (!reset) begin
            clklatch_q <= 1'b0;
            clkout_q   <= 1'b0;
            valid_q    <= 1'b0;
            buttons_q  <= '0;
            pressed_q  <= '0;
        end else begin
            clklatch_q <= (state_d == LATCH);
            clkout_q   <= (state_d == HIGH);
            valid_q    <= (state_q == DONE);
            if (state_q == DONE) begin
                buttons_q <= ~sr_q;
                pressed_q <= ~sr_q & ~buttons_q;
            end else begin
                pressed_q <= '0;
            end
        end
    end

    assign clklatch        = clklatch_q;
    assign clkout          = clkout_q;
    assign buttons         = buttons_q;
    assign buttons_valid   = valid_q;
    assign buttons_pressed = pressed_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
module tb_nes_pad_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       nes_data;
    logic       clklatch, clkout, buttons_valid;
    logic [7:0] buttons, buttons_pressed;

    int checks = 0;
    int errors = 0;

    // Controller model: pattern is active-low, bit i presented after pulse i.
    logic [7:0] pat  = 8'hFE;
    int         mode = 0;     // 0 model, 1 stuck high, 2 stuck low
    int         idx  = 0;

    always #5 clk = ~clk;

    nes_pad_reader #(
        .CLK_HZ       (12000),
        .POLL_HZ      (60),
        .HALF_CYCLES  (4),
        .LATCH_CYCLES (8)
    ) dut (
        .clock_50mhz     (clk),
        .reset           (rst_n),
        .nes_data        (nes_data),
        .clklatch        (clklatch),
        .clkout          (clkout),
        .buttons         (buttons),
        .buttons_valid   (buttons_valid),
        .buttons_pressed (buttons_pressed)
    );

    always @(posedge clklatch or posedge clkout) begin
        if (clklatch)    idx <= 0;
        else if (idx < 8) idx <= idx + 1;
    end

    assign nes_data = (mode == 1) ? 1'b1 :
                      (mode == 2) ? 1'b0 :
                      (idx < 8)   ? pat[idx[2:0]] : 1'b1;

    // Line monitor, sampled just after each rising edge.
    int  cyc = 0, rises = 0, hi_bad = 0, lo_bad = 0, run = 0;
    int  lat_len = 0, t_latch = 0, t_valid = 0, vcount = 0, stray = 0;
    logic ck_p = 1'b0, lat_p = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (clklatch && !lat_p) begin
            rises = 0; hi_bad = 0; lo_bad = 0; lat_len = 0; t_latch = cyc;
        end
        if (clklatch) lat_len = lat_len + 1;
        if (clkout !== ck_p) begin
            if (ck_p && run != 4) hi_bad = hi_bad + 1;
            if (!ck_p && rises > 0 && run != 4) lo_bad = lo_bad + 1;
            if (clkout) rises = rises + 1;
            run = 1;
        end else begin
            run = run + 1;
        end
        if (buttons_valid) begin t_valid = cyc; vcount = vcount + 1; end
        if (buttons_pressed !== 8'h00 && !buttons_valid) stray = stray + 1;
        ck_p  = clkout;
        lat_p = clklatch;
    end

    task automatic wait_valid(input int limit, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            if (buttons_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({clklatch, clkout, buttons_valid, buttons, buttons_pressed} !== 19'd0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0",
                {clklatch, clkout, buttons_valid, buttons, buttons_pressed});
        end
        rst_n = 1'b1;
        n = 0;
        while (clklatch !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 200) begin errors++; $display("FAIL first_latch got %0d exp 200", n); end
        n = 0;
        while (clklatch === 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (lat_len != 8) begin errors++; $display("FAIL latch_len got %0d exp 8", lat_len); end
    endtask

    task automatic test_single_a();
        int n; bit ok;
        wait_valid(300, n, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout got 0 exp 1"); end
        checks++;
        if (buttons !== 8'h01) begin errors++; $display("FAIL single_buttons got %h exp 01", buttons); end
        checks++;
        if (buttons_pressed !== 8'h01) begin errors++; $display("FAIL single_pressed got %h exp 01", buttons_pressed); end
        checks++;
        if (rises != 8) begin errors++; $display("FAIL pulse_count got %0d exp 8", rises); end
        checks++;
        if (hi_bad != 0 || lo_bad != 0) begin
            errors++; $display("FAIL pulse_width got hi=%0d lo=%0d exp 0", hi_bad, lo_bad);
        end
        checks++;
        if (t_valid - t_latch + 1 != 70) begin
            errors++; $display("FAIL single_latency got %0d exp 70", t_valid - t_latch + 1);
        end
        @(negedge clk);
        checks++;
        if (buttons_valid !== 1'b0 || buttons_pressed !== 8'h00) begin
            errors++; $display("FAIL strobe_width got %b/%h exp 0/00", buttons_valid, buttons_pressed);
        end
    endtask

    task automatic test_press_edge();
        int n; bit ok;
        pat = 8'hF6;
        wait_valid(300, n, ok);
        checks++;
        if (!ok || buttons !== 8'h09 || buttons_pressed !== 8'h08) begin
            errors++; $display("FAIL poll2 got %h/%h exp 09/08", buttons, buttons_pressed);
        end
        wait_valid(300, n, ok);
        checks++;
        if (!ok || buttons !== 8'h09 || buttons_pressed !== 8'h00) begin
            errors++; $display("FAIL poll3 got %h/%h exp 09/00", buttons, buttons_pressed);
        end
        checks++;
        if (n != 200) begin errors++; $display("FAIL poll3_spacing got %0d exp 200", n); end
    endtask

    task automatic test_mid_reset();
        int n, v0; bit ok;
        n = 0;
        while (!(rises == 3 && clkout === 1'b1) && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (n >= 400) begin errors++; $display("FAIL mid_wait got timeout exp pulse3"); end
        v0 = vcount;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({clklatch, clkout, buttons_valid, buttons} !== 11'd0) begin
            errors++; $display("FAIL mid_reset_lines got %h exp 0", {clklatch, clkout, buttons_valid, buttons});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(400, n, ok);
        checks++;
        if (vcount != v0 + 1) begin errors++; $display("FAIL mid_no_strobe got %0d exp %0d", vcount, v0 + 1); end
        checks++;
        if (!ok || n != 269 || buttons !== 8'h09 || buttons_pressed !== 8'h09) begin
            errors++; $display("FAIL mid_recover got n=%0d %h/%h exp 269 09/09", n, buttons, buttons_pressed);
        end
    endtask

    task automatic test_stuck();
        int n; bit ok;
        mode = 1;
        wait_valid(300, n, ok);
        checks++;
        if (!ok || buttons !== 8'h00) begin errors++; $display("FAIL stuck_high got %h exp 00", buttons); end
        mode = 2;
        wait_valid(300, n, ok);
        checks++;
        if (!ok || buttons !== 8'hFF || buttons_pressed !== 8'hFF) begin
            errors++; $display("FAIL stuck_low got %h/%h exp FF/FF", buttons, buttons_pressed);
        end
    endtask

    task automatic test_latency();
        int n; bit ok;
        mode = 0;
        pat  = 8'hFE;
        for (int i = 0; i < 5; i++) begin
            wait_valid(300, n, ok);
            checks++;
            if (!ok || n != 200 || t_valid - t_latch + 1 != 70) begin
                errors++; $display("FAIL latency_poll%0d got spacing=%0d lat=%0d exp 200/70",
                    i, n, t_valid - t_latch + 1);
            end
        end
        checks++;
        if (buttons !== 8'h01 || buttons_pressed !== 8'h00) begin
            errors++; $display("FAIL latency_buttons got %h/%h exp 01/00", buttons, buttons_pressed);
        end
        @(negedge clk);
        checks++;
        if (stray != 0) begin errors++; $display("FAIL stray_pressed got %0d exp 0", stray); end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_press_edge();
        test_mid_reset();
        test_stuck();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
